// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scanner with per-frame input snapshot
// Outputs are registered from the current scan position, so they trail the prescaler by one clock.
module seg_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int DIV          = 50000,
  parameter int BLANK        = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     en,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  hex_mode,
  input  logic                  lz_blank,
  output logic [7:0]            segO,
  output logic [DIGITS-1:0]     sig,
  output logic                  frame_start
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW:0]   ACT_LEN  = (CW+1)'(DIV - BLANK);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frm_q, frm_d;
  logic                  blink_off_q, blink_off_d;
  logic [4*DIGITS-1:0]   data_s_q, data_s_d;
  logic [DIGITS-1:0]     dp_s_q, dp_s_d;
  logic [DIGITS-1:0]     en_s_q, en_s_d;
  logic [DIGITS-1:0]     blink_s_q, blink_s_d;
  logic                  hex_s_q, hex_s_d;
  logic                  lz_s_q, lz_s_d;
  logic                  off_s_q, off_s_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     sig_q, sig_d;
  logic                  fs_q, fs_d;

  logic                  slot_end, frame_end, active, lz, vis, lz_run;
  logic [DIGITS-1:0]     lz_vec;
  logic [3:0]            nib;
  logic [7:0]            dec;

  function automatic logic [7:0] seg_decode(input logic [3:0] n, input logic hex);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hFC;  4'h1: s = 8'h60;  4'h2: s = 8'hDA;  4'h3: s = 8'hF2;
      4'h4: s = 8'h66;  4'h5: s = 8'hB6;  4'h6: s = 8'hBE;  4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;  4'h9: s = 8'hF6;  4'hA: s = 8'hEE;  4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;  4'hD: s = 8'h7A;  4'hE: s = 8'h9E;  default: s = 8'h8E;
    endcase
    if (!hex && n > 4'h9) s = 8'h00;
    return s;
  endfunction

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    lz_run = lz_s_q;
    lz_vec = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run    = lz_run & (data_s_q[4*i +: 4] == 4'd0);
      lz_vec[i] = lz_run && (i != 0);
    end
  end

  always_comb begin
    slot_end    = (cnt_q == CNT_LAST);
    frame_end   = slot_end && (idx_q == IDX_LAST);
    cnt_d       = slot_end ? '0 : cnt_q + CW'(1);
    idx_d       = idx_q;
    frm_d       = frm_q;
    blink_off_d = blink_off_q;
    data_s_d    = data_s_q;
    dp_s_d      = dp_s_q;
    en_s_d      = en_s_q;
    blink_s_d   = blink_s_q;
    hex_s_d     = hex_s_q;
    lz_s_d      = lz_s_q;
    off_s_d     = off_s_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    if (frame_end) begin
      data_s_d  = data;
      dp_s_d    = dp;
      en_s_d    = en;
      blink_s_d = blink;
      hex_s_d   = hex_mode;
      lz_s_d    = lz_blank;
      // The phase in force for the next frame is the one held before this boundary's toggle.
      off_s_d   = blink_off_q;
      if (frm_q == FRM_LAST) begin
        frm_d       = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end
  end

  always_comb begin
    active = ({1'b0, cnt_q} < ACT_LEN);
    nib    = data_s_q[4*idx_q +: 4];
    dec    = seg_decode(nib, hex_s_q);
    lz     = lz_vec[idx_q];
    vis    = en_s_q[idx_q] && !(blink_s_q[idx_q] && off_s_q) && !(lz && !dp_s_q[idx_q]);
    sig_d  = '1;
    seg_d  = '0;
    fs_d   = (cnt_q == '0) && (idx_q == '0);
    if (active && vis) begin
      sig_d[idx_q] = 1'b0;
      seg_d = lz ? {7'b0, dp_s_q[idx_q]} : {dec[7:1], dec[0] | dp_s_q[idx_q]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      frm_q       <= '0;
      blink_off_q <= 1'b0;
      data_s_q    <= '0;
      dp_s_q      <= '0;
      en_s_q      <= '0;
      blink_s_q   <= '0;
      hex_s_q     <= 1'b0;
      lz_s_q      <= 1'b0;
      off_s_q     <= 1'b0;
      seg_q       <= '0;
      sig_q       <= '1;
      fs_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frm_q       <= frm_d;
      blink_off_q <= blink_off_d;
      data_s_q    <= data_s_d;
      dp_s_q      <= dp_s_d;
      en_s_q      <= en_s_d;
      blink_s_q   <= blink_s_d;
      hex_s_q     <= hex_s_d;
      lz_s_q      <= lz_s_d;
      off_s_q     <= off_s_d;
      seg_q       <= seg_d;
      sig_q       <= sig_d;
      fs_q        <= fs_d;
    end
  end

  assign segO        = seg_q;
  assign sig         = sig_q;
  assign frame_start = fs_q;

endmodule
